// File: rtl/alu_op_sequencer.sv
// ALU operation sequencer: accepts an opcode, loads the Y operand from the bus,
// runs one ALU cycle with operand A on the bus, then writes the result back.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start; illegal opcode pulses err next cycle
// S_LOAD_Y | bus_in captured into Y at the closing edge
// S_EXEC   | alu_ctrl driven, alu_result captured into Z and flags
// S_WRITE  | Z driven on the bus, done pulsed, then back to idle
module alu_op_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  opcode,
  input  logic [1:0]  shift_sel,
  input  logic [15:0] bus_in,
  input  logic [15:0] alu_result,
  output logic [15:0] y_shifted,
  output logic [2:0]  alu_ctrl,
  output logic [15:0] bus_out,
  output logic        bus_drive,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        z_flag,
  output logic        n_flag
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD_Y = 2'd1,
    S_EXEC   = 2'd2,
    S_WRITE  = 2'd3
  } state_t;

  localparam logic [2:0] OP_ILLEGAL = 3'b111;

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [1:0]  shift_q, shift_d;
  logic [15:0] y_q, y_d;
  logic [15:0] z_q, z_d;
  logic        zf_q, zf_d;
  logic        nf_q, nf_d;
  logic        err_q, err_d;

  // State and datapath registers; reset puts flags at the "result zero" value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= 3'b000;
      shift_q <= 2'b00;
      y_q     <= 16'h0000;
      z_q     <= 16'h0000;
      zf_q    <= 1'b1;
      nf_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      shift_q <= shift_d;
      y_q     <= y_d;
      z_q     <= z_d;
      zf_q    <= zf_d;
      nf_q    <= nf_d;
      err_q   <= err_d;
    end
  end

  // Next-state and register-load logic; start is only looked at in idle.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    shift_d = shift_q;
    y_d     = y_q;
    z_d     = z_q;
    zf_d    = zf_q;
    nf_d    = nf_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (opcode == OP_ILLEGAL) begin
            err_d = 1'b1;
          end else begin
            op_d    = opcode;
            shift_d = shift_sel;
            state_d = S_LOAD_Y;
          end
        end
      end
      S_LOAD_Y: begin
        y_d     = bus_in;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        z_d     = alu_result;
        zf_d    = (alu_result == 16'h0000);
        nf_d    = alu_result[15];
        state_d = S_WRITE;
      end
      S_WRITE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Y operand shifter; the shifted-out bit is dropped.
  always_comb begin
    y_shifted = y_q;
    case (shift_q)
      2'b00:   y_shifted = y_q;
      2'b01:   y_shifted = {y_q[14:0], 1'b0};
      2'b10:   y_shifted = {1'b0, y_q[15:1]};
      2'b11:   y_shifted = {y_q[15], y_q[15:1]};
      default: y_shifted = y_q;
    endcase
  end

  // Outputs decoded from the current state; the ALU sees a no-op code outside exec.
  always_comb begin
    alu_ctrl  = (state_q == S_EXEC) ? op_q : OP_ILLEGAL;
    bus_drive = (state_q == S_WRITE);
    bus_out   = (state_q == S_WRITE) ? z_q : 16'h0000;
    done      = (state_q == S_WRITE);
    busy      = (state_q != S_IDLE);
    err       = err_q;
    z_flag    = zf_q;
    n_flag    = nf_q;
  end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 SHALL provide port clk, input, 1, single system clock; all state updates on rising edge.
REQ-002 SHALL provide port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL provide port start, input, 1, operation request, sampled only in IDLE.
REQ-004 SHALL provide port opcode, input, 3, ALU operation code in the shared ALU encoding (000 add, 001 and, 010 incY2, 011 invert bus, 100 or, 101 passY, 110 subtract, 111 illegal).
REQ-005 SHALL provide port shift_sel, input, 2, Y shift mode: 00 none, 01 left 1, 10 logical right 1, 11 arithmetic right 1.
REQ-006 SHALL provide port bus_in, input, 16, shared datapath bus value.
REQ-007 SHALL provide port alu_result, input, 16, combinational result returned from the ALU.
REQ-008 SHALL provide port y_shifted, output, 16, shifted Y operand to the ALU.
REQ-009 SHALL provide port alu_ctrl, output, 3, ALU control code.
REQ-010 SHALL provide port bus_out, output, 16, value driven toward the bus.
REQ-011 SHALL provide port bus_drive, output, 1, bus_out valid and owning the bus.
REQ-012 SHALL provide ports busy, done, err, z_flag, n_flag, output, 1 each: not idle; one-cycle completion pulse; one-cycle illegal-op pulse; result zero; result bit 15.

Function
REQ-013 SHALL implement states IDLE, LOAD_Y, EXEC, WRITE; busy=1 in every state except IDLE.
REQ-014 IDLE with start=1 and opcode!=111 SHALL latch opcode and shift_sel and go to LOAD_Y next cycle.
REQ-015 IDLE with start=1 and opcode=111 SHALL stay IDLE and assert err for exactly the following cycle; no other register changes.
REQ-016 LOAD_Y SHALL capture bus_in into Y register at its closing edge and go to EXEC.
REQ-017 y_shifted SHALL be combinational from Y and latched shift_sel; left shift fills 0; logical right fills 0; arithmetic right replicates Y[15]; widths stay 16 bits, shifted-out bit discarded.
REQ-018 EXEC SHALL drive alu_ctrl=latched opcode, capture alu_result into Z register at its closing edge (bus_in carries operand A this cycle), and go to WRITE.
REQ-019 alu_ctrl SHALL be 3'b111 in every state except EXEC.
REQ-020 z_flag and n_flag SHALL update at the EXEC closing edge from alu_result (z=all bits zero, n=bit 15) and hold until the next EXEC.
REQ-021 WRITE SHALL assert bus_drive=1, bus_out=Z, done=1 for exactly one cycle, then return to IDLE.
REQ-022 bus_out SHALL be 16'h0000 whenever bus_drive=0.
REQ-023 Latency SHALL be fixed: start accepted at edge N -> done high in cycle N+3; next start accepted no earlier than the cycle after WRITE.
REQ-024 start asserted while busy=1 SHALL be ignored without error and without altering latched opcode/shift_sel.
REQ-025 opcode and shift_sel changes after acceptance SHALL not affect the running operation.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, Y=0, Z=0, latched opcode=000, shift_sel=00, busy=0, done=0, err=0, bus_drive=0, bus_out=0, alu_ctrl=111, z_flag=1, n_flag=0.
REQ-027 Reset asserted mid-operation (any state) SHALL abort it with no done pulse; first start is accepted on the first rising edge with rst_n high.

Verification
REQ-028 Add: opcode 000, shift 01, bus_in 0x0003 in LOAD_Y, 0x0010 in EXEC, ALU model -> y_shifted 0x0006, bus_out 0x0016 with done in cycle N+3, z=0, n=0.
REQ-029 Subtract to zero: opcode 110, shift 00, Y 0x1234, A 0x1234 -> bus_out 0x0000, z_flag=1, n_flag=0.
REQ-030 Arithmetic shift: opcode 101, shift 11, Y 0x8002 -> y_shifted 0xC001, bus_out 0xC001, n_flag=1; shift 10 same Y -> 0x4001.
REQ-031 Illegal op: start with opcode 111 in IDLE -> err high one cycle, busy stays 0, alu_ctrl stays 111, no done.
REQ-032 Busy/back-to-back: start held high continuously -> operations accepted every 4 cycles, done pulses 4 cycles apart, start during LOAD_Y/EXEC/WRITE ignored.
REQ-033 Reset mid-EXEC: drop rst_n during EXEC -> all outputs at reset values immediately, no done; new op after release completes with normal latency.
